// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller and video stage.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

  // A 180-degree turn keeps the axis bit and flips the sense bit.
  function automatic logic is_reversal(input dir_t cur, input dir_t req);
    return (cur[1] == req[1]) && (cur[0] != req[0]);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low button: two-flop synchronizer, stable-level debounce and
// a registered one-cycle pulse on each debounced press.
module key_debounce
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    warm_q, warm_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[0], key_ni};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // Presses are only armed once a real released sample has been seen, so a
    // key held through reset stays silent until it is let go.
    warm_d  = {warm_q[0], 1'b1};
    armed_d = armed_q | (warm_q[1] & sync_q[1]);
    prev_d  = stable_q;
    press_d = prev_q & ~stable_q & armed_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      warm_q   <= 2'b00;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/snake_key_ctrl.sv
// Debounced direction buttons for the snake: a pending direction is chosen
// from key presses and committed to the display stage on each move tick.
module snake_key_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       pixel_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key,
  input  logic       move_tick,
  output logic [3:0] key_press,
  output logic [1:0] dir_pend,
  output logic [1:0] dir,
  output logic       dir_chg
);

  dir_t pend_q, pend_d;
  dir_t dir_q, dir_d;
  logic chg_q, chg_d;
  dir_t req_dir;
  logic req_vld;
  logic accept;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (pixel_clk),
      .rst_ni (sys_rst_n),
      .key_ni (key[i]),
      .press_o(key_press[i])
    );
  end

  always_comb begin
    req_vld = |key_press;
    req_dir = DIR_UP;
    if (key_press[0])      req_dir = DIR_UP;
    else if (key_press[1]) req_dir = DIR_DOWN;
    else if (key_press[2]) req_dir = DIR_LEFT;
    else if (key_press[3]) req_dir = DIR_RIGHT;

    // Reversal is judged against the committed direction, not the pending one.
    accept = req_vld && !is_reversal(dir_q, req_dir);
    pend_d = accept ? req_dir : pend_q;
    dir_d  = move_tick ? pend_d : dir_q;
    chg_d  = move_tick && (pend_d != dir_q);
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      pend_q <= DIR_RIGHT;
      dir_q  <= DIR_RIGHT;
      chg_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      dir_q  <= dir_d;
      chg_q  <= chg_d;
    end
  end

  assign dir_pend = pend_q;
  assign dir      = dir_q;
  assign dir_chg  = chg_q;

endmodule

// File: tb/tb_snake_key_ctrl.sv
// Directed bench for snake_key_ctrl with a cycle-exact key_press scoreboard.
module tb_snake_key_ctrl;

  localparam int unsigned DEB = 8;
  localparam int PRESS_LAT = DEB + 3;
  localparam int EVAL_WAIT = PRESS_LAT + 2;
  localparam int REL = DEB + 6;

  logic       pixel_clk = 1'b0;
  logic       sys_rst_n;
  logic [3:0] key;
  logic       move_tick;
  logic [3:0] key_press;
  logic [1:0] dir_pend;
  logic [1:0] dir;
  logic       dir_chg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc_at;
    logic [3:0] mask;
  } press_t;

  press_t     exp_q[$];
  logic [3:0] mon_exp;

  snake_key_ctrl #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .move_tick(move_tick),
    .key_press(key_press),
    .dir_pend (dir_pend),
    .dir      (dir),
    .dir_chg  (dir_chg)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every cycle key_press must equal the scheduled pulse for that cycle, or zero.
  always @(negedge pixel_clk) begin
    mon_exp = 4'b0000;
    if (exp_q.size() > 0 && exp_q[0].cyc_at == cyc) begin
      mon_exp = exp_q[0].mask;
      void'(exp_q.pop_front());
    end
    check("key_press", key_press, mon_exp);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] mask);
    press_t p;
    key = key & ~mask;
    p.cyc_at = cyc + PRESS_LAT;
    p.mask = mask;
    exp_q.push_back(p);
  endtask

  task automatic release_key(input logic [3:0] mask);
    key = key | mask;
    wait_cycles(REL);
  endtask

  task automatic tick();
    move_tick = 1'b1;
    wait_cycles(1);
    move_tick = 1'b0;
    @(negedge pixel_clk);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] e_pend, input logic [1:0] e_dir,
                           input logic e_chg);
    check({tag, "_pend"}, {2'b00, dir_pend}, {2'b00, e_pend});
    check({tag, "_dir"},  {2'b00, dir},      {2'b00, e_dir});
    check({tag, "_chg"},  {3'b000, dir_chg}, {3'b000, e_chg});
  endtask

  initial begin
    key = 4'hF;
    move_tick = 1'b0;
    sys_rst_n = 1'b0;
    wait_cycles(3);
    chk_state("reset", 2'b11, 2'b11, 1'b0);
    sys_rst_n = 1'b1;
    wait_cycles(6);

    // up from right, committed at tick
    press_key(4'b0001);
    wait_cycles(EVAL_WAIT);
    chk_state("up_pend", 2'b00, 2'b11, 1'b0);
    tick();
    chk_state("up_tick", 2'b00, 2'b00, 1'b1);
    wait_cycles(1);
    chk_state("up_after", 2'b00, 2'b00, 1'b0);
    release_key(4'b0001);

    // right from up
    press_key(4'b1000);
    wait_cycles(EVAL_WAIT);
    chk_state("right_pend", 2'b11, 2'b00, 1'b0);
    tick();
    chk_state("right_tick", 2'b11, 2'b11, 1'b1);
    release_key(4'b1000);

    // left is a reversal of right
    press_key(4'b0100);
    wait_cycles(EVAL_WAIT);
    chk_state("left_rej", 2'b11, 2'b11, 1'b0);
    tick();
    chk_state("left_rej_tick", 2'b11, 2'b11, 1'b0);
    release_key(4'b0100);

    // glitches on down: 5-low bursts, then one DEB-1 burst
    for (int i = 0; i < 4; i++) begin
      key[1] = 1'b0;
      wait_cycles(5);
      key[1] = 1'b1;
      wait_cycles(3);
    end
    key[1] = 1'b0;
    wait_cycles(DEB - 1);
    key[1] = 1'b1;
    wait_cycles(REL);
    chk_state("glitch", 2'b11, 2'b11, 1'b0);

    // up then down (exactly DEB low cycles) before any tick
    press_key(4'b0001);
    wait_cycles(EVAL_WAIT);
    chk_state("up2_pend", 2'b00, 2'b11, 1'b0);
    press_key(4'b0010);
    wait_cycles(DEB);
    key[1] = 1'b1;
    wait_cycles(EVAL_WAIT - DEB);
    chk_state("down_pend", 2'b01, 2'b11, 1'b0);
    tick();
    chk_state("down_tick", 2'b01, 2'b01, 1'b1);

    // release bounce on up
    key[0] = 1'b1; wait_cycles(2);
    key[0] = 1'b0; wait_cycles(2);
    key[0] = 1'b1; wait_cycles(3);
    key[0] = 1'b0; wait_cycles(1);
    release_key(4'b0001);
    chk_state("bounce", 2'b01, 2'b01, 1'b0);

    // left from down
    press_key(4'b0100);
    wait_cycles(EVAL_WAIT);
    chk_state("left_pend", 2'b10, 2'b01, 1'b0);
    tick();
    chk_state("left_tick", 2'b10, 2'b10, 1'b1);
    release_key(4'b0100);

    // up and right together: up wins
    press_key(4'b1001);
    wait_cycles(EVAL_WAIT);
    chk_state("prio", 2'b00, 2'b10, 1'b0);
    release_key(4'b1001);

    // press coincides with tick: down bypasses pending up
    press_key(4'b0010);
    wait_cycles(PRESS_LAT);
    tick();
    chk_state("bypass", 2'b01, 2'b01, 1'b1);
    release_key(4'b0010);

    // press coincides with tick but is a reversal
    press_key(4'b0001);
    wait_cycles(PRESS_LAT);
    tick();
    chk_state("bypass_rev", 2'b01, 2'b01, 1'b0);
    release_key(4'b0001);

    // back-to-back ticks with nothing pending
    move_tick = 1'b1;
    wait_cycles(1);
    chk_state("b2b_1", 2'b01, 2'b01, 1'b0);
    wait_cycles(1);
    move_tick = 1'b0;
    chk_state("b2b_2", 2'b01, 2'b01, 1'b0);

    // right pending, then current direction down re-selected
    press_key(4'b1000);
    wait_cycles(EVAL_WAIT);
    chk_state("right_pend2", 2'b11, 2'b01, 1'b0);
    release_key(4'b1000);
    press_key(4'b0010);
    wait_cycles(EVAL_WAIT);
    chk_state("same_pend", 2'b01, 2'b01, 1'b0);
    tick();
    chk_state("same_tick", 2'b01, 2'b01, 1'b0);
    release_key(4'b0010);

    // set up dir=right, pending=up
    press_key(4'b1000);
    wait_cycles(EVAL_WAIT);
    tick();
    chk_state("setup_right", 2'b11, 2'b11, 1'b1);
    release_key(4'b1000);
    press_key(4'b0001);
    wait_cycles(EVAL_WAIT);
    chk_state("setup_up", 2'b00, 2'b11, 1'b0);
    release_key(4'b0001);

    // reset while left is mid-debounce and held afterwards
    key[2] = 1'b0;
    wait_cycles(4);
    sys_rst_n = 1'b0;
    wait_cycles(1);
    sys_rst_n = 1'b1;
    chk_state("mid_rst", 2'b11, 2'b11, 1'b0);
    check("mid_rst_press", key_press, 4'b0000);
    wait_cycles(3 * DEB);
    chk_state("held_rst", 2'b11, 2'b11, 1'b0);
    release_key(4'b0100);

    // fresh press of left after release is reported (and rejected as reversal)
    press_key(4'b0100);
    wait_cycles(EVAL_WAIT);
    chk_state("left_again", 2'b11, 2'b11, 1'b0);
    release_key(4'b0100);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL press_queue: observed %0d outstanding expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
